pe_bypass_ctrl: RTL and testbench
=================================

Name: pe_bypass_ctrl

Overview:
- IF-stage bypass control generator for the PE pipeline (IF -> ID -> EX -> WB).
- Compares the incoming instruction's RF read addresses against the destination of the instruction currently in ID, one step ahead of the operand mux in the ID stage.
- Drives that mux's registered per-port bypass-enable and source-select inputs. Also generates the load-use stall and a saturating stall counter.
- WB-distance hazards are resolved by the RF-write-port internal bypass in the ID-stage mux, so they are not handled here.

Parameters:
- LOAD_USE_STALL, 1: 1 = an LSU result consumed at distance 1 stalls IF one cycle; 0 = LSU result is forwarded from EX like other sources.
- CNT_WIDTH, 16: width of the stall counter.

Ports:
- iClk  in  1  clock
- iReset  in  1  asynchronous, active-high reset
- iStall  in  1  global pipeline freeze (memory/CP); dominates everything
- iIF_Valid  in  1  IF instruction valid
- iIF_RF_Read_Addr_A  in  `DEF_RF_INDEX_WIDTH  port A read address
- iIF_RF_Read_Addr_B  in  `DEF_RF_INDEX_WIDTH  port B read address
- iIF_Read_En_A  in  1  instruction reads port A
- iIF_Read_En_B  in  1  instruction reads port B (0 for immediate-form)
- iIF_RF_Write_En  in  1  instruction writes RF
- iIF_RF_Write_Addr  in  `DEF_RF_INDEX_WIDTH  destination register
- iIF_Result_Src  in  2  producing unit, encoded with `RISC24_BYPASS_SRC_ALU/MUL/LSU/SHADOW (00/01/10/11)
- oIF_BP_Bypass_Read_A  out  1  registered; port A forwarded from EX
- oIF_BP_Bypass_Read_B  out  1  registered; port B forwarded from EX
- oIF_BP_Bypass_Sel_A  out  2  registered; port A forwarding source
- oIF_BP_Bypass_Sel_B  out  2  registered; port B forwarding source
- oIF_Stall  out  1  combinational load-use stall request to IF
- oID_Valid  out  1  ID slot valid (bubble indicator)
- oStall_Count  out  CNT_WIDTH  saturating load-use stall cycle counter

Behaviour:
- State: ID slot {valid, we, waddr, src}, four bypass output registers, stall counter.
- Reset (async, iReset=1): slot valid=0, we=0, waddr=0, src=ALU; all Bypass_Read=0; Sel=2'b00; oStall_Count=0; oID_Valid=0.
- Match rule per port X: iIF_Valid & iIF_Read_En_X & slot.valid & slot.we & (Read_Addr_X == slot.waddr) & (Read_Addr_X > 1). r0/r1 never match.
- Hazard = LOAD_USE_STALL & (slot.src == LSU) & (matchA | matchB).
- oIF_Stall = hazard & ~iStall; purely combinational, no latency.
- Clock edge with iStall=1: all registers hold, counter holds.
- Clock edge with iStall=0, hazard=0:
  - slot <= {iIF_Valid, iIF_RF_Write_En & iIF_Valid, iIF_RF_Write_Addr, iIF_Result_Src}.
  - Bypass_Read_X <= matchX; Sel_X <= slot.src if matchX, else 2'b00.
- Clock edge with iStall=0, hazard=1:
  - Bubble: slot.valid <= 0, slot.we <= 0.
  - Both Bypass_Read <= 0, both Sel <= 0.
  - Counter increments, saturating at all-ones.
  - The held instruction is re-presented next cycle. Its producer is then in EX, so it reaches ID at WB distance and needs no flag.
- Latency: flags valid in the cycle the consumer occupies ID, exactly 1 clock after IF presentation.
- Both ports matching the same producer: both flags set, both Sel equal.
- Port A and port B have the same address: identical flags.
- iIF_Valid=0: slot becomes invalid, flags 0, no stall.
- Reset asserted mid-stall: everything cleared immediately. After release, the first edge behaves as with an empty slot.

Test Plan:
- Reset: iReset=1 mid-traffic -> all flags 0, Sel 00, oStall_Count 0, oID_Valid 0 asynchronously.
- ALU forward: cycle0 ADD w r5 src=ALU; cycle1 reads A=r5 -> cycle2 Bypass_Read_A=1, Sel_A=00, Bypass_Read_B=0.
- Port B, MUL source: MUL w r7 then read B=r7 -> Bypass_Read_B=1, Sel_B=01. Same with destination r1 -> no flag.
- Load-use (LOAD_USE_STALL=1): LD w r9 then consumer reads A=r9:
  - oIF_Stall=1 for exactly 1 cycle.
  - Next cycle oID_Valid=0 and flags 0.
  - Re-presented consumer gives flags 0.
  - oStall_Count=1.
- Freeze dominance: hazard present with iStall=1 for 3 cycles -> oIF_Stall=0, registers and counter unchanged. Release -> one stall cycle occurs.
- Saturation: CNT_WIDTH=4, 20 load-use hazards -> oStall_Count stays at 15.

Source files
------------

// File: rtl/pe_bypass_ctrl.sv
// IF-stage bypass control: compares the IF instruction's read ports against the
// ID-slot destination, registers per-port EX-forward flags and raises load-use stalls.
`ifndef DEF_RF_INDEX_WIDTH
`define DEF_RF_INDEX_WIDTH 5
`endif
`ifndef RISC24_BYPASS_SRC_ALU
`define RISC24_BYPASS_SRC_ALU 2'b00
`endif
`ifndef RISC24_BYPASS_SRC_LSU
`define RISC24_BYPASS_SRC_LSU 2'b10
`endif

module pe_bypass_ctrl #(
    parameter bit          LOAD_USE_STALL = 1'b1,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                           iClk,
    input  logic                           iReset,
    input  logic                           iStall,
    input  logic                           iIF_Valid,
    input  logic [`DEF_RF_INDEX_WIDTH-1:0] iIF_RF_Read_Addr_A,
    input  logic [`DEF_RF_INDEX_WIDTH-1:0] iIF_RF_Read_Addr_B,
    input  logic                           iIF_Read_En_A,
    input  logic                           iIF_Read_En_B,
    input  logic                           iIF_RF_Write_En,
    input  logic [`DEF_RF_INDEX_WIDTH-1:0] iIF_RF_Write_Addr,
    input  logic [1:0]                     iIF_Result_Src,
    output logic                           oIF_BP_Bypass_Read_A,
    output logic                           oIF_BP_Bypass_Read_B,
    output logic [1:0]                     oIF_BP_Bypass_Sel_A,
    output logic [1:0]                     oIF_BP_Bypass_Sel_B,
    output logic                           oIF_Stall,
    output logic                           oID_Valid,
    output logic [CNT_WIDTH-1:0]           oStall_Count
);

    localparam int unsigned RW      = `DEF_RF_INDEX_WIDTH;
    localparam logic [1:0]  SRC_ALU = `RISC24_BYPASS_SRC_ALU;
    localparam logic [1:0]  SRC_LSU = `RISC24_BYPASS_SRC_LSU;

    logic                 slot_valid_q, slot_valid_d;
    logic                 slot_we_q,    slot_we_d;
    logic [RW-1:0]        slot_waddr_q, slot_waddr_d;
    logic [1:0]           slot_src_q,   slot_src_d;
    logic                 bp_rd_a_q,    bp_rd_a_d;
    logic                 bp_rd_b_q,    bp_rd_b_d;
    logic [1:0]           bp_sel_a_q,   bp_sel_a_d;
    logic [1:0]           bp_sel_b_q,   bp_sel_b_d;
    logic [CNT_WIDTH-1:0] cnt_q,        cnt_d;

    logic match_a, match_b, hazard;

    // r0/r1 are hard-wired registers and are never forwarded
    assign match_a = iIF_Valid & iIF_Read_En_A & slot_valid_q & slot_we_q
                   & (iIF_RF_Read_Addr_A == slot_waddr_q) & (iIF_RF_Read_Addr_A > RW'(1));
    assign match_b = iIF_Valid & iIF_Read_En_B & slot_valid_q & slot_we_q
                   & (iIF_RF_Read_Addr_B == slot_waddr_q) & (iIF_RF_Read_Addr_B > RW'(1));
    assign hazard  = LOAD_USE_STALL & (slot_src_q == SRC_LSU) & (match_a | match_b);

    assign oIF_Stall = hazard & ~iStall;

    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_we_d    = slot_we_q;
        slot_waddr_d = slot_waddr_q;
        slot_src_d   = slot_src_q;
        bp_rd_a_d    = bp_rd_a_q;
        bp_rd_b_d    = bp_rd_b_q;
        bp_sel_a_d   = bp_sel_a_q;
        bp_sel_b_d   = bp_sel_b_q;
        cnt_d        = cnt_q;
        if (!iStall) begin
            if (hazard) begin
                // insert a bubble; the consumer is re-presented at WB distance
                slot_valid_d = 1'b0;
                slot_we_d    = 1'b0;
                bp_rd_a_d    = 1'b0;
                bp_rd_b_d    = 1'b0;
                bp_sel_a_d   = 2'b00;
                bp_sel_b_d   = 2'b00;
                if (cnt_q != {CNT_WIDTH{1'b1}}) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end else begin
                slot_valid_d = iIF_Valid;
                slot_we_d    = iIF_RF_Write_En & iIF_Valid;
                slot_waddr_d = iIF_RF_Write_Addr;
                slot_src_d   = iIF_Result_Src;
                bp_rd_a_d    = match_a;
                bp_rd_b_d    = match_b;
                bp_sel_a_d   = match_a ? slot_src_q : 2'b00;
                bp_sel_b_d   = match_b ? slot_src_q : 2'b00;
            end
        end
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            slot_valid_q <= 1'b0;
            slot_we_q    <= 1'b0;
            slot_waddr_q <= '0;
            slot_src_q   <= SRC_ALU;
            bp_rd_a_q    <= 1'b0;
            bp_rd_b_q    <= 1'b0;
            bp_sel_a_q   <= 2'b00;
            bp_sel_b_q   <= 2'b00;
            cnt_q        <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_we_q    <= slot_we_d;
            slot_waddr_q <= slot_waddr_d;
            slot_src_q   <= slot_src_d;
            bp_rd_a_q    <= bp_rd_a_d;
            bp_rd_b_q    <= bp_rd_b_d;
            bp_sel_a_q   <= bp_sel_a_d;
            bp_sel_b_q   <= bp_sel_b_d;
            cnt_q        <= cnt_d;
        end
    end

    assign oIF_BP_Bypass_Read_A = bp_rd_a_q;
    assign oIF_BP_Bypass_Read_B = bp_rd_b_q;
    assign oIF_BP_Bypass_Sel_A  = bp_sel_a_q;
    assign oIF_BP_Bypass_Sel_B  = bp_sel_b_q;
    assign oID_Valid            = slot_valid_q;
    assign oStall_Count         = cnt_q;

endmodule

// File: tb/tb_pe_bypass_ctrl.sv
// Randomized and directed bench for pe_bypass_ctrl against an instruction-level pipeline model.
`ifndef DEF_RF_INDEX_WIDTH
`define DEF_RF_INDEX_WIDTH 5
`endif

module tb_pe_bypass_ctrl;

    localparam int unsigned RW = `DEF_RF_INDEX_WIDTH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall = 1'b0;
    logic          v = 1'b0, ea = 1'b0, eb = 1'b0, we = 1'b0;
    logic [RW-1:0] ra = '0, rb = '0, wa = '0;
    logic [1:0]    src = 2'b00;

    logic          bra, brb, stl, idv;
    logic [1:0]    sla, slb;
    logic [15:0]   cnt;
    logic          s_bra, s_brb, s_stl, s_idv;
    logic [1:0]    s_sla, s_slb;
    logic [3:0]    s_cnt;

    pe_bypass_ctrl dut (
        .iClk(clk), .iReset(rst), .iStall(stall), .iIF_Valid(v),
        .iIF_RF_Read_Addr_A(ra), .iIF_RF_Read_Addr_B(rb),
        .iIF_Read_En_A(ea), .iIF_Read_En_B(eb),
        .iIF_RF_Write_En(we), .iIF_RF_Write_Addr(wa), .iIF_Result_Src(src),
        .oIF_BP_Bypass_Read_A(bra), .oIF_BP_Bypass_Read_B(brb),
        .oIF_BP_Bypass_Sel_A(sla), .oIF_BP_Bypass_Sel_B(slb),
        .oIF_Stall(stl), .oID_Valid(idv), .oStall_Count(cnt)
    );

    pe_bypass_ctrl #(.LOAD_USE_STALL(1'b1), .CNT_WIDTH(4)) dut_sat (
        .iClk(clk), .iReset(rst), .iStall(stall), .iIF_Valid(v),
        .iIF_RF_Read_Addr_A(ra), .iIF_RF_Read_Addr_B(rb),
        .iIF_Read_En_A(ea), .iIF_Read_En_B(eb),
        .iIF_RF_Write_En(we), .iIF_RF_Write_Addr(wa), .iIF_Result_Src(src),
        .oIF_BP_Bypass_Read_A(s_bra), .oIF_BP_Bypass_Read_B(s_brb),
        .oIF_BP_Bypass_Sel_A(s_sla), .oIF_BP_Bypass_Sel_B(s_slb),
        .oIF_Stall(s_stl), .oID_Valid(s_idv), .oStall_Count(s_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Model: the instruction occupying ID, and the flags the consumer in ID should see
    typedef struct {
        bit       valid;
        bit       writes;
        int       dest;
        int       unit;
    } instr_t;

    instr_t in_id;
    bit     m_bra, m_brb;
    int     m_sla, m_slb;
    int     stalls_total;

    function automatic void model_reset();
        in_id = '{valid: 0, writes: 0, dest: 0, unit: 0};
        m_bra = 0; m_brb = 0; m_sla = 0; m_slb = 0;
        stalls_total = 0;
    endfunction

    // Does the IF instruction's port consume the result of the instruction in ID?
    function automatic bit consumes(input bit en, input int reg_no);
        return v && en && in_id.valid && in_id.writes && reg_no == in_id.dest && reg_no >= 2;
    endfunction

    function automatic bit load_use();
        return in_id.unit == 2 && (consumes(ea, int'(ra)) || consumes(eb, int'(rb)));
    endfunction

    task automatic check_all();
        check("stall",    32'(stl),   32'(load_use() && !stall));
        check("id_valid", 32'(idv),   32'(in_id.valid));
        check("bp_rd_a",  32'(bra),   32'(m_bra));
        check("bp_rd_b",  32'(brb),   32'(m_brb));
        check("bp_sel_a", 32'(sla),   32'(m_sla));
        check("bp_sel_b", 32'(slb),   32'(m_slb));
        check("cnt16",    32'(cnt),   32'(stalls_total > 65535 ? 65535 : stalls_total));
        check("cnt4",     32'(s_cnt), 32'(stalls_total > 15 ? 15 : stalls_total));
    endtask

    // Check before the edge, advance the model across it, settle 1 time unit after
    task automatic step();
        bit ma, mb, hz;
        instr_t nxt;
        @(negedge clk);
        check_all();
        ma = consumes(ea, int'(ra));
        mb = consumes(eb, int'(rb));
        hz = load_use();
        nxt = '{valid: v, writes: v && we, dest: int'(wa), unit: int'(src)};
        @(posedge clk);
        if (!stall) begin
            if (hz) begin
                in_id.valid = 0; in_id.writes = 0;
                m_bra = 0; m_brb = 0; m_sla = 0; m_slb = 0;
                stalls_total++;
            end else begin
                m_bra = ma; m_brb = mb;
                m_sla = ma ? in_id.unit : 0;
                m_slb = mb ? in_id.unit : 0;
                in_id = nxt;
            end
        end
        #1;
    endtask

    task automatic set_in(input bit iv, input bit iea, input int ira, input bit ieb, input int irb,
                          input bit iwe, input int iwa, input int isrc);
        v = iv; ea = iea; ra = RW'(ira); eb = ieb; rb = RW'(irb);
        we = iwe; wa = RW'(iwa); src = 2'(isrc);
    endtask

    // Asynchronous reset pulse between clock edges
    task automatic pulse_reset();
        #1 rst = 1'b1;
        #1;
        model_reset();
        check("rst_bp_a",  32'(bra), 0);
        check("rst_bp_b",  32'(brb), 0);
        check("rst_sel_a", 32'(sla), 0);
        check("rst_sel_b", 32'(slb), 0);
        check("rst_idv",   32'(idv), 0);
        check("rst_cnt",   32'(cnt), 0);
        #1 rst = 1'b0;
    endtask

    initial begin
        int c0;
        model_reset();
        #12 rst = 1'b0;
        @(posedge clk); #1;
        check("init_idv", 32'(idv), 0);
        check("init_cnt", 32'(cnt), 0);

        // ALU forward on port A
        set_in(1, 0, 0, 0, 0, 1, 5, 0); step();
        set_in(1, 1, 5, 1, 6, 0, 0, 0); step();
        check("alu_rd_a", 32'(bra), 1);
        check("alu_sel_a", 32'(sla), 0);
        check("alu_rd_b", 32'(brb), 0);

        // MUL forward on port B, then r1 destination never forwards
        set_in(1, 0, 0, 0, 0, 1, 7, 1); step();
        set_in(1, 1, 3, 1, 7, 0, 0, 0); step();
        check("mul_rd_b", 32'(brb), 1);
        check("mul_sel_b", 32'(slb), 1);
        set_in(1, 0, 0, 0, 0, 1, 1, 1); step();
        set_in(1, 1, 1, 1, 1, 0, 0, 0); step();
        check("r1_rd_a", 32'(bra), 0);
        check("r1_rd_b", 32'(brb), 0);

        // Same register on both ports from one producer
        set_in(1, 0, 0, 0, 0, 1, 12, 3); step();
        set_in(1, 1, 12, 1, 12, 0, 0, 0); step();
        check("both_rd_a", 32'(bra), 1);
        check("both_rd_b", 32'(brb), 1);
        check("both_sel_a", 32'(sla), 3);
        check("both_sel_b", 32'(slb), 3);

        // Load-use: one stall cycle, bubble, re-presented consumer unflagged
        pulse_reset();
        set_in(1, 0, 0, 0, 0, 1, 9, 2); step();
        set_in(1, 1, 9, 0, 0, 1, 4, 0);
        #1 check("lu_stall", 32'(stl), 1);
        step();
        check("lu_bubble", 32'(idv), 0);
        check("lu_flags", 32'(bra), 0);
        check("lu_nostall", 32'(stl), 0);
        step();
        check("lu_reissue", 32'(bra), 0);
        check("lu_cnt", 32'(cnt), 1);

        // Freeze dominates a pending load-use hazard
        set_in(1, 0, 0, 0, 0, 1, 9, 2); step();
        set_in(1, 1, 9, 0, 0, 0, 0, 0);
        stall = 1'b1;
        c0 = int'(cnt);
        for (int i = 0; i < 3; i++) begin
            #1 check("frz_stall", 32'(stl), 0);
            step();
            check("frz_cnt", 32'(cnt), 32'(c0));
            check("frz_idv", 32'(idv), 1);
        end
        stall = 1'b0;
        #1 check("frz_release", 32'(stl), 1);
        step();
        check("frz_cnt_inc", 32'(cnt), 32'(c0 + 1));
        step();

        // Saturation of the narrow counter
        pulse_reset();
        for (int i = 0; i < 20; i++) begin
            set_in(1, 0, 0, 0, 0, 1, 9, 2); step();
            set_in(1, 0, 0, 1, 9, 0, 0, 0); step(); step();
        end
        check("sat_cnt4", 32'(s_cnt), 15);
        check("sat_cnt16", 32'(cnt), 20);

        // Randomized traffic, with occasional freezes and mid-run resets
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
                   $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
                   $urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
            stall = ($urandom_range(0, 6) == 0);
            if ($urandom_range(0, 299) == 0) pulse_reset();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
